// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings
// driven by the E stage and the scheduler's state encoding.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for ops that occupy the unit for several cycles.
  function automatic logic is_multicycle(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Pipeline <-> multiply/divide unit signals. The pipeline (master) issues
// ops and reports MD instructions in D; the unit (slave) returns HI/LO,
// its busy flag and the stall request.
interface md_sched_if;
  import md_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_instr_d;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  modport master (
    output start, md_op, src_a, src_b, md_instr_d,
    input  busy, hi, lo, md_stall
  );

  modport slave (
    input  start, md_op, src_a, src_b, md_instr_d,
    output busy, hi, lo, md_stall
  );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces the {hi, lo} pair an
// op would write and flags a zero divisor so the scheduler can suppress
// the write-back.
module md_arith
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        is_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] safe_b;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);

  // Divide on magnitudes, then restore signs: quotient truncates toward
  // zero and the remainder follows the dividend. 0x80000000 / -1 falls
  // out naturally as 0x80000000 rem 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    abs_a       = (is_signed && a[31]) ? (32'd0 - a) : a;
    abs_b       = (is_signed && b[31]) ? (32'd0 - b) : b;
    div_by_zero = (b == 32'd0);
    safe_b      = div_by_zero ? 32'd1 : abs_b;
    quo_u       = abs_a / safe_b;
    rem_u       = abs_a % safe_b;
    prod_s      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u      = {32'd0, a} * {32'd0, b};
    result      = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        result[63:32] = a[31] ? (32'd0 - rem_u) : rem_u;
        result[31:0]  = (a[31] ^ b[31]) ? (32'd0 - quo_u) : quo_u;
      end
      MD_DIVU:  result = {rem_u, quo_u};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler. Owns HI/LO, latches the result of
// an op at issue and releases it to HI/LO once the op's latency has been
// counted out. Requests a pipeline stall while an MD instruction waits in
// D and the unit is starting or busy.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  md_sched_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q;
  logic             busy_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi_q;
  logic [31:0]      pend_lo_q;
  logic             pend_wr_q;

  logic [63:0]      arith_result;
  logic             arith_div0;

  md_arith u_arith (
    .op          (md.md_op),
    .a           (md.src_a),
    .b           (md.src_b),
    .result      (arith_result),
    .div_by_zero (arith_div0)
  );

  // Scheduler FSM: issue, latency count, deferred HI/LO write-back.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      count_q   <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md.start) begin
            case (md.md_op)
              MD_MULT, MD_MULTU: begin
                state_q   <= ST_RUN;
                busy_q    <= 1'b1;
                count_q   <= MULT_LOAD;
                pend_hi_q <= arith_result[63:32];
                pend_lo_q <= arith_result[31:0];
                pend_wr_q <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                state_q   <= ST_RUN;
                busy_q    <= 1'b1;
                count_q   <= DIV_LOAD;
                pend_hi_q <= arith_result[63:32];
                pend_lo_q <= arith_result[31:0];
                pend_wr_q <= !arith_div0;
              end
              MD_MTHI: hi_q <= md.src_a;
              MD_MTLO: lo_q <= md.src_a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (count_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy     = busy_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_stall = md.md_instr_d & (busy_q | md.start);

  // Issue while busy is a hazard-logic bug; the op is dropped by the FSM.
  a_no_mul_div_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(md.start && busy_q && is_multicycle(md.md_op)));

  // MTHI/MTLO issued while busy is likewise dropped.
  a_no_mt_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(md.start && busy_q && (md.md_op == MD_MTHI || md.md_op == MD_MTLO)));

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: multiply/divide latency and results,
// divide by zero, MTHI/MTLO, stall request, and reset during an op.
module tb_md_sched;
  import md_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  md_sched_if bus ();

  md_sched #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multi-cycle op and check busy, stall and HI/LO over its life.
  task automatic run_op(input string name, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic instr_d,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.start      = 1'b1;
    bus.md_op      = op;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.md_instr_d = instr_d;
    @(negedge clk);
    check({name, " start busy"}, 64'(bus.busy), 64'd0);
    check({name, " start stall"}, 64'(bus.md_stall), 64'(instr_d));
    tick();
    bus.start = 1'b0;
    bus.src_a = 32'hDEAD_BEEF;
    bus.src_b = 32'h0000_0001;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check($sformatf("%s busy c%0d", name, i), 64'(bus.busy), 64'd1);
      check($sformatf("%s stall c%0d", name, i), 64'(bus.md_stall), 64'(instr_d));
      check($sformatf("%s hi hold c%0d", name, i), 64'(bus.hi), 64'(old_hi));
      check($sformatf("%s lo hold c%0d", name, i), 64'(bus.lo), 64'(old_lo));
      tick();
    end
    @(negedge clk);
    check({name, " done busy"}, 64'(bus.busy), 64'd0);
    check({name, " done stall"}, 64'(bus.md_stall), 64'd0);
    check({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
    bus.md_instr_d = 1'b0;
    tick();
  endtask

  // Single-cycle move to HI or LO.
  task automatic move(input string name, input md_op_e op, input logic [31:0] val,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = val;
    bus.src_b = 32'd0;
    @(negedge clk);
    check({name, " start busy"}, 64'(bus.busy), 64'd0);
    tick();
    bus.start = 1'b0;
    bus.src_a = 32'd0;
    @(negedge clk);
    check({name, " busy"}, 64'(bus.busy), 64'd0);
    check({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.md_op      = MD_MULT;
    bus.src_a      = 32'd0;
    bus.src_b      = 32'd0;
    bus.md_instr_d = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset stall", 64'(bus.md_stall), 64'd0);
    tick();
    reset          = 1'b0;
    bus.md_instr_d = 1'b0;
    tick();

    run_op("mult", MD_MULT, 32'd7, 32'hFFFF_FFFD, 5, 1'b0,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 1'b0,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd2, 32'd14);
    run_op("div neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0,
           32'd2, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    move("mthi 11", MD_MTHI, 32'h11, 32'h11, 32'hFFFF_FFFD);
    move("mtlo 22", MD_MTLO, 32'h22, 32'h11, 32'h22);
    run_op("div0", MD_DIV, 32'd5, 32'd0, 10, 1'b0,
           32'h11, 32'h22, 32'h11, 32'h22);

    move("mthi", MD_MTHI, 32'h1234_5678, 32'h1234_5678, 32'h22);
    move("mtlo", MD_MTLO, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0);

    run_op("multu stall", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b1,
           32'h1234_5678, 32'h9ABC_DEF0, 32'd1, 32'hFFFF_FFFE);
    run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0,
           32'd1, 32'hFFFF_FFFE, 32'd0, 32'h8000_0000);
    run_op("div rem", MD_DIV, 32'hFFFF_FFF1, 32'd4, 10, 1'b0,
           32'd0, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFD);

    // Reset during the third busy cycle of a divide.
    bus.start = 1'b1;
    bus.md_op = MD_DIV;
    bus.src_a = 32'd100;
    bus.src_b = 32'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("abort busy c3", 64'(bus.busy), 64'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort hi", 64'(bus.hi), 64'd0);
    check("abort lo", 64'(bus.lo), 64'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("abort quiet busy %0d", i), 64'(bus.busy), 64'd0);
      check($sformatf("abort quiet hilo %0d", i), {bus.hi, bus.lo}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
